// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
//   Sequencer for a 3x3 signed systolic MAC array. Holds one 3x3 A operand
//   and one 3x3 B operand, then on start optionally clears the array, feeds
//   the skewed row/column streams, waits for the wavefront to drain, and
//   pulses done when every PE accumulator holds its final value.
//
//   Build option: MAC_SEQ_AUTOCLEAR_EN
//     defined   -> a one-cycle CLEAR state pulls array_rst_n low before FEED,
//                  so every run starts from zero accumulators.
//     undefined -> IDLE goes straight to FEED and runs accumulate onto the
//                  previous results; array_rst_n then follows rst_n only.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   wr_en/wr_sel        operand write strobe, bank select (0 = A, 1 = B)
//   wr_addr/wr_data     row-major element index 0..8, element value
//   start               run request, honoured only in IDLE
//   busy                high in every state except IDLE
//   done                one-cycle pulse, array results are final
//   array_rst_n         reset to the MAC array
//   din_r1..din_r3      row feeds for A rows 0..2
//   din_c1..din_c3      column feeds for B columns 0..2
module mac_seq_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              array_rst_n,
    output logic [DATA_W-1:0] din_r1,
    output logic [DATA_W-1:0] din_r2,
    output logic [DATA_W-1:0] din_r3,
    output logic [DATA_W-1:0] din_c1,
    output logic [DATA_W-1:0] din_c2,
    output logic [DATA_W-1:0] din_c3
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q [9];
    logic [DATA_W-1:0] a_d [9];
    logic [DATA_W-1:0] b_q [9];
    logic [DATA_W-1:0] b_d [9];
    logic [DATA_W-1:0] row_q [3];
    logic [DATA_W-1:0] row_d [3];
    logic [DATA_W-1:0] col_q [3];
    logic [DATA_W-1:0] col_d [3];
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              arst_n_q, arst_n_d;

    // Operand banks: writes land only while idle, out-of-range indices drop.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (state_q == S_IDLE && wr_en && wr_addr <= 4'd8) begin
            if (wr_sel) begin
                b_d[wr_addr] = wr_data;
            end else begin
                a_d[wr_addr] = wr_data;
            end
        end
    end

    // Next-state and phase counter (feed index in FEED, drain count in DRAIN).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef MAC_SEQ_AUTOCLEAR_EN
                    state_d = S_CLEAR;
`else
                    state_d = S_FEED;
`endif
                    cnt_d = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == 3'd4) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == 3'd1) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are derived from the upcoming state so that, once registered,
    // they line up with the state they belong to. The feeds read the
    // post-write bank so a write issued alongside start is used by the run.
    // Row i carries A[i][t-i], column j carries B[t-j][j]; the table below is
    // that skew unrolled over t = 0..4.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
`ifdef MAC_SEQ_AUTOCLEAR_EN
        arst_n_d = (state_d != S_CLEAR);
`else
        arst_n_d = 1'b1;
`endif
        row_d = '{default: '0};
        col_d = '{default: '0};
        if (state_d == S_FEED) begin
            case (cnt_d)
                3'd0: begin
                    row_d[0] = a_d[0];
                    col_d[0] = b_d[0];
                end
                3'd1: begin
                    row_d[0] = a_d[1];
                    row_d[1] = a_d[3];
                    col_d[0] = b_d[3];
                    col_d[1] = b_d[1];
                end
                3'd2: begin
                    row_d[0] = a_d[2];
                    row_d[1] = a_d[4];
                    row_d[2] = a_d[6];
                    col_d[0] = b_d[6];
                    col_d[1] = b_d[4];
                    col_d[2] = b_d[2];
                end
                3'd3: begin
                    row_d[1] = a_d[5];
                    row_d[2] = a_d[7];
                    col_d[1] = b_d[7];
                    col_d[2] = b_d[5];
                end
                3'd4: begin
                    row_d[2] = a_d[8];
                    col_d[2] = b_d[8];
                end
                default: begin
                    row_d = '{default: '0};
                    col_d = '{default: '0};
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '{default: '0};
            b_q      <= '{default: '0};
            row_q    <= '{default: '0};
            col_q    <= '{default: '0};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            arst_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            row_q    <= row_d;
            col_q    <= col_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            arst_n_q <= arst_n_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign array_rst_n = arst_n_q;
    assign din_r1      = row_q[0];
    assign din_r2      = row_q[1];
    assign din_r3      = row_q[2];
    assign din_c1      = col_q[0];
    assign din_c2      = col_q[1];
    assign din_c3      = col_q[2];

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Testbench for mac_seq_ctrl. A behavioural 3x3 systolic array is driven by
// the DUT feeds; expected results are matrix products of the bench's own copy
// of the operand banks, queued at start and checked by a monitor at done.
module tb_mac_seq_ctrl;

    localparam int DATA_W = 8;
`ifdef MAC_SEQ_AUTOCLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif
    localparam int LAT = 8 + CLR;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic              wr_sel;
    logic [3:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              busy;
    logic              done;
    logic              array_rst_n;
    logic [DATA_W-1:0] din_r1, din_r2, din_r3;
    logic [DATA_W-1:0] din_c1, din_c2, din_c3;

    mac_seq_ctrl #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .array_rst_n(array_rst_n),
        .din_r1     (din_r1),
        .din_r2     (din_r2),
        .din_r3     (din_r3),
        .din_c1     (din_c1),
        .din_c2     (din_c2),
        .din_c3     (din_c3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_seen = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_n;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural systolic array ----------------
    logic signed [DATA_W-1:0] dr [3];
    logic signed [DATA_W-1:0] dc [3];
    logic signed [DATA_W-1:0] rreg [3][3];
    logic signed [DATA_W-1:0] creg [3][3];
    logic signed [DATA_W-1:0] mr [3][4];
    logic signed [DATA_W-1:0] mc [4][3];
    int acc [3][3];

    assign dr[0] = din_r1;
    assign dr[1] = din_r2;
    assign dr[2] = din_r3;
    assign dc[0] = din_c1;
    assign dc[1] = din_c2;
    assign dc[2] = din_c3;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            mr[i][0] = dr[i];
            mc[0][i] = dc[i];
            for (int j = 0; j < 3; j++) begin
                mr[i][j+1] = rreg[i][j];
                mc[i+1][j] = creg[i][j];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (!array_rst_n) begin
                    rreg[i][j] <= '0;
                    creg[i][j] <= '0;
                    acc[i][j]  <= 0;
                end else begin
                    rreg[i][j] <= mr[i][j];
                    creg[i][j] <= mc[i][j];
                    acc[i][j]  <= acc[i][j] + int'(mr[i][j]) * int'(mc[i][j]);
                end
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct packed {
        int                           start_cyc;
        int                           done_cyc;
        logic [8:0][DATA_W-1:0]       a;
        logic [8:0][DATA_W-1:0]       b;
        logic [8:0][31:0]             c;
    } exp_t;

    exp_t q[$];
    logic [DATA_W-1:0] ra [9];
    logic [DATA_W-1:0] rb [9];
    int                rc [9];

    task automatic ref_clear();
        for (int k = 0; k < 9; k++) begin
            ra[k] = '0;
            rb[k] = '0;
            rc[k] = 0;
        end
    endtask

    task automatic ref_write(input logic sel, input logic [3:0] addr, input logic [DATA_W-1:0] data);
        if (addr <= 4'd8) begin
            if (sel) rb[addr] = data;
            else     ra[addr] = data;
        end
    endtask

    task automatic push_run();
        exp_t e;
        int   s;
        e.start_cyc = cyc;
        e.done_cyc  = cyc + LAT;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++)
                    s += int'($signed(ra[3*i+k])) * int'($signed(rb[3*k+j]));
                rc[3*i+j] = (CLR == 1) ? s : rc[3*i+j] + s;
            end
        end
        for (int k = 0; k < 9; k++) begin
            e.a[k] = ra[k];
            e.b[k] = rb[k];
            e.c[k] = rc[k];
        end
        q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    exp_t              h;
    bit                have;
    int                t;
    logic [DATA_W-1:0] er [3];
    logic [DATA_W-1:0] ec [3];
    logic              eb, ed, ea;

    always @(negedge clk) begin
        if (rst_n) begin
            have = (q.size() > 0);
            h    = have ? q[0] : '0;
            ed   = have && (cyc == h.done_cyc);
            eb   = have && (cyc > h.start_cyc) && (cyc <= h.done_cyc);
            ea   = rst_seen && !(CLR == 1 && have && cyc == h.start_cyc + 1);
            t    = cyc - h.start_cyc - CLR - 1;
            for (int i = 0; i < 3; i++) begin
                er[i] = '0;
                ec[i] = '0;
                if (have && t - i >= 0 && t - i <= 2) begin
                    er[i] = h.a[3*i + t - i];
                    ec[i] = h.b[3*(t - i) + i];
                end
            end
            chk("busy", {31'd0, busy}, {31'd0, eb});
            chk("done", {31'd0, done}, {31'd0, ed});
            chk("array_rst_n", {31'd0, array_rst_n}, {31'd0, ea});
            chk("din_r1", 32'(din_r1), 32'(er[0]));
            chk("din_r2", 32'(din_r2), 32'(er[1]));
            chk("din_r3", 32'(din_r3), 32'(er[2]));
            chk("din_c1", 32'(din_c1), 32'(ec[0]));
            chk("din_c2", 32'(din_c2), 32'(ec[1]));
            chk("din_c3", 32'(din_c3), 32'(ec[2]));
            if (have && cyc >= h.done_cyc) begin
                for (int k = 0; k < 9; k++)
                    chk($sformatf("cell%0d_%0d", k / 3, k % 3), acc[k/3][k%3], h.c[k]);
                void'(q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic sel, input logic [3:0] addr, input logic [DATA_W-1:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr;
        wr_data = data;
        ref_write(sel, addr, data);
        next_cycle();
        wr_en = 1'b0;
    endtask

    task automatic load(input int av [9], input int bv [9]);
        for (int k = 0; k < 9; k++) do_write(1'b0, 4'(k), DATA_W'(av[k]));
        for (int k = 0; k < 9; k++) do_write(1'b1, 4'(k), DATA_W'(bv[k]));
    endtask

    // Start in the current cycle, optionally with a same-cycle write.
    task automatic do_start(input bit w, input logic sel, input logic [3:0] addr, input logic [DATA_W-1:0] data);
        start = 1'b1;
        if (w) begin
            wr_en   = 1'b1;
            wr_sel  = sel;
            wr_addr = addr;
            wr_data = data;
            ref_write(sel, addr, data);
        end
        push_run();
        next_cycle();
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic run(input bit w, input logic sel, input logic [3:0] addr, input logic [DATA_W-1:0] data);
        do_start(w, sel, addr, data);
        repeat (LAT) next_cycle();
    endtask

    int av [9];
    int bv [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        ref_clear();
        next_cycle();
        next_cycle();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_array_rst_n", {31'd0, array_rst_n}, 32'd0);
        chk("reset_din", 32'(din_r1 | din_r2 | din_r3 | din_c1 | din_c2 | din_c3), 32'd0);
        rst_n = 1'b1;
        next_cycle();
        next_cycle();

        // A = 1..9, B = identity
        for (int k = 0; k < 9; k++) begin
            av[k] = k + 1;
            bv[k] = (k % 4 == 0) ? 1 : 0;
        end
        load(av, bv);
        run(0, 1'b0, 4'd0, '0);

        // A all -1, B all 2, twice back to back
        for (int k = 0; k < 9; k++) begin
            av[k] = -1;
            bv[k] = 2;
        end
        load(av, bv);
        run(0, 1'b0, 4'd0, '0);
        run(0, 1'b0, 4'd0, '0);

        // Ignored starts and a dropped write of 55 while busy
        for (int k = 0; k < 9; k++) begin
            av[k] = k + 1;
            bv[k] = (k % 4 == 0) ? 1 : 0;
        end
        load(av, bv);
        do_start(0, 1'b0, 4'd0, '0);
        next_cycle();
        next_cycle();
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_addr = 4'd4;
        wr_data = 8'd55;
        next_cycle();
        start = 1'b0;
        wr_en = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        run(0, 1'b0, 4'd0, '0);

        // Out-of-range write dropped, then start with a same-cycle write
        do_write(1'b0, 4'd12, 8'h5A);
        do_write(1'b1, 4'd9, 8'h33);
        run(1, 1'b1, 4'd8, 8'd7);

        // Reset at mid-run, then a run on cleared banks
        do_start(0, 1'b0, 4'd0, '0);
        next_cycle();
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        q.delete();
        ref_clear();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        run(0, 1'b0, 4'd0, '0);

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            int nw;
            nw = int'($urandom_range(0, 8));
            for (int k = 0; k < nw; k++)
                do_write(1'($urandom), 4'($urandom_range(0, 10)), DATA_W'($urandom));
            if ($urandom_range(0, 1) == 1)
                run(1, 1'($urandom), 4'($urandom_range(0, 9)), DATA_W'($urandom));
            else
                run(0, 1'b0, 4'd0, '0);
        end

        next_cycle();
        next_cycle();
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
